bus_source_arbiter: RTL and testbench

BUS_SOURCE_ARBITER -- requirements
Module: bus_source_arbiter

---
 rtl/bus_pkg.sv | 13 +
 rtl/prio_enc.sv | 24 ++
 rtl/bus_source_arbiter.sv | 131 +++++++++++++
 tb/tb_bus_source_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus source arbiter: the default source count and
// the arbiter state encoding.
package bus_pkg;

  localparam int N_SRC_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder. Outputs the binary index of the lowest set
// request bit and a found flag. The index is always below N.
module prio_enc #(
  parameter int N = 32,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Scan downward so that the lowest set bit is written last and wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Bus source arbiter: picks one of N_SRC requesters (fixed priority or
// round-robin) and holds the grant locked for multi-cycle transfers.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no live grant; valid=0, S holds its last value
//   ST_GRANT | grant issued; re-arbitrates each cycle unless hold locks it
//   ST_LOCK  | grant frozen while hold=1 and the granted source requests
module bus_source_arbiter
  import bus_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEF,
  parameter int SEL_W   = $clog2(N_SRC),
  parameter int RR_MODE = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [N_SRC-1:0] req,
  input  logic             hold,
  output logic [SEL_W-1:0] S,
  output logic [N_SRC-1:0] grant,
  output logic             valid,
  output logic             multi
);

  arb_state_e       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [N_SRC-1:0] r_grant, w_grant_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_multi, w_multi_nxt;

  logic [N_SRC-1:0] w_rr_mask;
  logic [N_SRC-1:0] w_req_msk;
  logic [N_SRC-1:0] w_onehot;
  logic [SEL_W-1:0] w_idx_all, w_idx_msk, w_winner;
  logic             w_found_all, w_found_msk;
  logic             w_cur_req;
  logic             w_arb;

  always_comb begin
    w_rr_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_rr_mask[i] = (i >= int'(r_ptr));
    end
  end

  assign w_req_msk = req & w_rr_mask;

  prio_enc #(.N(N_SRC), .W(SEL_W)) u_enc_all (
    .i_req   (req),
    .o_idx   (w_idx_all),
    .o_found (w_found_all)
  );

  prio_enc #(.N(N_SRC), .W(SEL_W)) u_enc_msk (
    .i_req   (w_req_msk),
    .o_idx   (w_idx_msk),
    .o_found (w_found_msk)
  );

  // Round-robin falls back to the unmasked search when nothing sits at or above ptr.
  assign w_winner = ((RR_MODE != 0) && w_found_msk) ? w_idx_msk : w_idx_all;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_onehot[i] = (int'(w_winner) == i);
    end
  end

  // Grant register is zero in IDLE, so this is only true for a live grant.
  assign w_cur_req = |(req & r_grant);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_multi_nxt = 1'b0;
    w_arb       = 1'b1;

    case (r_state)
      ST_IDLE:           w_arb = 1'b1;
      ST_GRANT, ST_LOCK: w_arb = !(hold && w_cur_req);
      default:           w_arb = 1'b1;
    endcase

    if (!w_arb) begin
      w_state_nxt = ST_LOCK;
    end else if (w_found_all) begin
      w_state_nxt = ST_GRANT;
      w_sel_nxt   = w_winner;
      w_grant_nxt = w_onehot;
      w_valid_nxt = 1'b1;
      w_multi_nxt = ($countones(req) > 1);
      if (RR_MODE != 0) begin
        w_ptr_nxt = (w_winner == SEL_W'(N_SRC - 1)) ? '0 : w_winner + SEL_W'(1);
      end
    end else begin
      w_state_nxt = ST_IDLE;
      w_grant_nxt = '0;
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_multi <= w_multi_nxt;
    end
  end

  assign S     = r_sel;
  assign grant = r_grant;
  assign valid = r_valid;
  assign multi = r_multi;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter: fixed-priority, round-robin and a 26-source
// round-robin instance checked through an expected-result queue.
module tb_bus_source_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_n;
  logic [31:0] fix_req, rr_req;
  logic [25:0] np_req;
  logic        fix_hold, rr_hold, np_hold;

  logic [4:0]  fix_S, rr_S, np_S;
  logic [31:0] fix_grant, rr_grant;
  logic [25:0] np_grant;
  logic        fix_valid, rr_valid, np_valid;
  logic        fix_multi, rr_multi, np_multi;

  bus_source_arbiter #(.N_SRC(32), .RR_MODE(0)) u_fix (
    .clk(clk), .clr_n(clr_n), .req(fix_req), .hold(fix_hold),
    .S(fix_S), .grant(fix_grant), .valid(fix_valid), .multi(fix_multi)
  );

  bus_source_arbiter #(.N_SRC(32), .RR_MODE(1)) u_rr (
    .clk(clk), .clr_n(clr_n), .req(rr_req), .hold(rr_hold),
    .S(rr_S), .grant(rr_grant), .valid(rr_valid), .multi(rr_multi)
  );

  bus_source_arbiter #(.N_SRC(26), .RR_MODE(1)) u_np (
    .clk(clk), .clr_n(clr_n), .req(np_req), .hold(np_hold),
    .S(np_S), .grant(np_grant), .valid(np_valid), .multi(np_multi)
  );

  typedef struct {
    int          dut;
    logic [63:0] grant;
    logic [5:0]  sel;
    logic        valid;
    logic        multi;
  } exp_t;

  typedef struct {
    logic [31:0] req;
    logic        hold;
    logic [5:0]  sel;
    logic [31:0] grant;
    logic        valid;
    logic        multi;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];
  int   total = 0;
  int   bad   = 0;

  // reference state for the 26-source round-robin instance
  int   m_st, m_sel, m_ptr;
  bit   m_valid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int dut, input logic [5:0] s, input logic v, input logic m);
    exp_t e;
    e.dut   = dut;
    e.sel   = s;
    e.valid = v;
    e.multi = m;
    e.grant = v ? (64'd1 << s) : 64'd0;
    sb.push_back(e);
  endtask

  task automatic settle_check(input string tag);
    exp_t        e;
    logic [63:0] a_g;
    logic [5:0]  a_s;
    logic        a_v, a_m;
    string       pre;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty at check", tag);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin a_g = {32'd0, fix_grant}; a_s = {1'b0, fix_S}; a_v = fix_valid; a_m = fix_multi; pre = "fix"; end
        1: begin a_g = {32'd0, rr_grant};  a_s = {1'b0, rr_S};  a_v = rr_valid;  a_m = rr_multi;  pre = "rr";  end
        default: begin a_g = {38'd0, np_grant}; a_s = {1'b0, np_S}; a_v = np_valid; a_m = np_multi; pre = "np"; end
      endcase
      chk($sformatf("%s %s S", tag, pre),     {58'd0, a_s}, {58'd0, e.sel});
      chk($sformatf("%s %s grant", tag, pre), a_g, e.grant);
      chk($sformatf("%s %s valid", tag, pre), {63'd0, a_v}, {63'd0, e.valid});
      chk($sformatf("%s %s multi", tag, pre), {63'd0, a_m}, {63'd0, e.multi});
    end
  endtask

  task automatic step_rr(input string tag, input logic [31:0] r, input logic h,
                         input logic [5:0] s, input logic v, input logic m);
    @(negedge clk);
    rr_req  = r;
    rr_hold = h;
    push(1, s, v, m);
    settle_check(tag);
  endtask

  task automatic model_np(input logic [25:0] r, input logic h, output exp_t e);
    bit found;
    int idx;
    e.dut = 2;
    e.multi = 1'b0;
    if (m_st != 0 && h && r[m_sel]) begin
      m_st = 2;
    end else if (r == 26'd0) begin
      m_st    = 0;
      m_valid = 1'b0;
    end else begin
      found = 1'b0;
      for (int k = 0; k < 26; k++) begin
        idx = (m_ptr + k) % 26;
        if (!found && r[idx]) begin
          found = 1'b1;
          m_sel = idx;
        end
      end
      m_ptr   = (m_sel + 1) % 26;
      m_valid = 1'b1;
      m_st    = 1;
      e.multi = ($countones(r) > 1);
    end
    e.sel   = 6'(m_sel);
    e.valid = m_valid;
    e.grant = m_valid ? (64'd1 << m_sel) : 64'd0;
  endtask

  task automatic step_np(input string tag, input logic [25:0] r, input logic h);
    exp_t e;
    @(negedge clk);
    np_req  = r;
    np_hold = h;
    model_np(r, h, e);
    sb.push_back(e);
    settle_check(tag);
    chk({tag, " np S range"}, {63'd0, (np_S < 5'd26)}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [25:0] r;

    vt[0]  = '{req:32'hFFFF_FFFF, hold:1'b0, sel:6'd0,  grant:32'h0000_0001, valid:1'b1, multi:1'b1};
    vt[1]  = '{req:32'h0400_0010, hold:1'b0, sel:6'd4,  grant:32'h0000_0010, valid:1'b1, multi:1'b1};
    vt[2]  = '{req:32'h0000_0000, hold:1'b0, sel:6'd4,  grant:32'h0000_0000, valid:1'b0, multi:1'b0};
    vt[3]  = '{req:32'h0000_0000, hold:1'b0, sel:6'd4,  grant:32'h0000_0000, valid:1'b0, multi:1'b0};
    vt[4]  = '{req:32'h8000_0000, hold:1'b0, sel:6'd31, grant:32'h8000_0000, valid:1'b1, multi:1'b0};
    vt[5]  = '{req:32'h8000_0008, hold:1'b1, sel:6'd31, grant:32'h8000_0000, valid:1'b1, multi:1'b0};
    vt[6]  = '{req:32'h8000_0001, hold:1'b1, sel:6'd31, grant:32'h8000_0000, valid:1'b1, multi:1'b0};
    vt[7]  = '{req:32'h0000_0001, hold:1'b1, sel:6'd0,  grant:32'h0000_0001, valid:1'b1, multi:1'b0};
    vt[8]  = '{req:32'h0000_0006, hold:1'b0, sel:6'd1,  grant:32'h0000_0002, valid:1'b1, multi:1'b1};
    vt[9]  = '{req:32'h0000_0000, hold:1'b1, sel:6'd1,  grant:32'h0000_0000, valid:1'b0, multi:1'b0};
    vt[10] = '{req:32'h0000_0100, hold:1'b1, sel:6'd8,  grant:32'h0000_0100, valid:1'b1, multi:1'b0};
    vt[11] = '{req:32'h0000_0101, hold:1'b0, sel:6'd0,  grant:32'h0000_0001, valid:1'b1, multi:1'b1};

    clr_n    = 1'b0;
    fix_req  = 32'hFFFF_FFFF;
    rr_req   = 32'hFFFF_FFFF;
    np_req   = 26'h3FF_FFFF;
    fix_hold = 1'b0;
    rr_hold  = 1'b0;
    np_hold  = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset fix S",     {59'd0, fix_S}, 64'd0);
    chk("reset fix grant", {32'd0, fix_grant}, 64'd0);
    chk("reset fix valid", {63'd0, fix_valid}, 64'd0);
    chk("reset fix multi", {63'd0, fix_multi}, 64'd0);
    chk("reset rr valid",  {63'd0, rr_valid}, 64'd0);
    chk("reset np valid",  {63'd0, np_valid}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) clr_n = 1'b1;
      fix_req  = vt[i].req;
      fix_hold = vt[i].hold;
      rr_req   = (i == 0) ? 32'hFFFF_FFFF : 32'd0;
      np_req   = (i == 0) ? 26'h3FF_FFFF : 26'd0;
      sb.push_back('{dut:0, grant:{32'd0, vt[i].grant}, sel:vt[i].sel,
                     valid:vt[i].valid, multi:vt[i].multi});
      if (i == 0) push(1, 6'd0, 1'b1, 1'b1);
      settle_check($sformatf("vec%0d", i));
    end
    fix_req = 32'd0;

    // round-robin instance sits at S=0, ptr=1 after the release above
    step_rr("rr pre",  32'h0000_0008, 1'b0, 6'd3, 1'b1, 1'b0);
    step_rr("rr lock", 32'h0000_0008, 1'b1, 6'd3, 1'b1, 1'b0);

    // reset while locked: lock discarded, pointer back to 0
    @(negedge clk);
    clr_n   = 1'b0;
    rr_req  = 32'h0000_0007;
    rr_hold = 1'b0;
    #1;
    chk("midreset rr S",     {59'd0, rr_S}, 64'd0);
    chk("midreset rr grant", {32'd0, rr_grant}, 64'd0);
    chk("midreset rr valid", {63'd0, rr_valid}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    push(1, 6'd0, 1'b1, 1'b1);
    settle_check("rr seq0");
    step_rr("rr seq1", 32'h0000_0007, 1'b0, 6'd1, 1'b1, 1'b1);
    step_rr("rr seq2", 32'h0000_0007, 1'b0, 6'd2, 1'b1, 1'b1);
    step_rr("rr seq3", 32'h0000_0007, 1'b0, 6'd0, 1'b1, 1'b1);

    step_rr("rr w31",  32'h8000_0000, 1'b0, 6'd31, 1'b1, 1'b0);
    step_rr("rr wrap", 32'h8000_0001, 1'b0, 6'd0,  1'b1, 1'b1);

    step_rr("lk g3",    32'h0000_0008, 1'b0, 6'd3, 1'b1, 1'b0);
    step_rr("lk hold",  32'h0000_0008, 1'b1, 6'd3, 1'b1, 1'b0);
    step_rr("lk add1",  32'h0000_000A, 1'b1, 6'd3, 1'b1, 1'b0);
    step_rr("lk drop3", 32'h0000_0002, 1'b1, 6'd1, 1'b1, 1'b0);
    step_rr("rr under", 32'h0000_0003, 1'b0, 6'd0, 1'b1, 1'b1);
    step_rr("rr idle",  32'h0000_0000, 1'b0, 6'd0, 1'b0, 1'b0);

    // 26-source instance: idle since the mid-run reset
    m_st    = 0;
    m_sel   = 0;
    m_ptr   = 0;
    m_valid = 1'b0;
    step_np("np top", 26'h200_0000, 1'b0);
    chk("np top S25", {59'd0, np_S}, 64'd25);

    for (int n = 0; n < 400; n++) begin
      r = 26'($urandom);
      case ($urandom_range(0, 3))
        0:       r = 26'd0;
        1:       r = 26'd1 << $urandom_range(0, 25);
        2:       r = r & 26'($urandom);
        default: ;
      endcase
      step_np($sformatf("np rnd%0d", n), r, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
